vga_sync_receiver: RTL
======================

VGA_SYNC_RECEIVER -- requirements
Module: vga_sync_receiver

Interface
REQ-001 Parameters (name, default, meaning): H_TOTAL 800 clocks/line; V_TOTAL 525 lines/frame; H_START 144 first visible clock after hsync fall; V_START 35 first visible line after frame start; H_ACTIVE 640; V_ACTIVE 480; LOCK_FRAMES 2 consecutive good frames to lock.
REQ-002 clk  in  1  pixel clock (25 MHz); sole clock; all logic on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 hsync_in  in  1  horizontal sync, active-low, asynchronous to clk.
REQ-005 vsync_in  in  1  vertical sync, active-low, asynchronous to clk.
REQ-006 pixel_in  in  3  RGB pixel bits.
REQ-007 rx_x, rx_y  out  10 each  recovered visible coordinate.
REQ-008 rx_valid  out  1  rx_x/rx_y/rx_pixel valid (locked and in visible window).
REQ-009 rx_pixel  out  3  pixel aligned to rx_x/rx_y.
REQ-010 frame_start  out  1  one-cycle pulse at each frame boundary.
REQ-011 line_len, frame_lines  out  10 each  last measured line period (clocks) and frame length (lines).
REQ-012 locked  out  1  high in LOCKED state.
REQ-013 err_count  out  8  saturating lock-loss counter (see Configuration).

Function
REQ-014 hsync_in, vsync_in synchronized by 2 flops; pixel_in delayed 2 flops for equal alignment.
REQ-015 Line start = synchronized hsync falling edge; that cycle hcnt<=0, line_len<=hcnt+1 (saturate 1023); otherwise hcnt increments, saturating at 1023.
REQ-016 Synchronized vsync falling edge sets vflag; at next line start vcnt<=0, frame_lines<=vcnt+1 (saturate 1023), frame_start pulses, vflag clears; other line starts increment vcnt (saturate 1023).
REQ-017 Per-frame bad flag set by any line start with line_len != H_TOTAL; cleared at frame_start.
REQ-018 FSM SEARCH -> CHECK at first frame_start, good count=0.
REQ-019 CHECK: at frame_start, good frame (bad clear, frame_lines==V_TOTAL) increments good count; reaching LOCK_FRAMES -> LOCKED; bad frame zeroes good count, stays CHECK.
REQ-020 LOCKED: bad line length, frame_lines != V_TOTAL at frame_start, or hcnt reaching 1023 -> SEARCH, err_count increments.
REQ-021 hcnt reaching 1023 in CHECK -> SEARCH (watchdog, no error count).
REQ-022 rx_valid registered: locked && H_START<=hcnt<H_START+H_ACTIVE && V_START<=vcnt<V_START+V_ACTIVE; rx_x=hcnt-H_START, rx_y=vcnt-V_START, rx_pixel=delayed pixel, same cycle.
REQ-023 Latency pixel_in to rx_pixel 3 clocks; rx_x/rx_y/rx_pixel hold 0 when rx_valid low.
REQ-024 Simultaneous hsync and vsync falls: vflag set and consumed at that same line start.

Reset
REQ-025 rst asserts: synchronizers to 1 (inactive sync), pixel delay 0, hcnt/vcnt 0, vflag 0, FSM SEARCH, good count 0.
REQ-026 All outputs 0 during and after reset until updated by REQ-015..REQ-022.
REQ-027 Reset mid-frame discards measurements; relock requires full SEARCH/CHECK sequence.

Configuration
REQ-028 Macro VGA_RX_ERRCNT_EN defined: err_count 8-bit saturating at 255, cleared by rst only.
REQ-029 VGA_RX_ERRCNT_EN undefined: err_count tied to 0, no counter logic; all other behaviour identical.

Verification
REQ-030 Standard 640x480 timing, 3 frames -> locked rises at third frame_start; line_len=800, frame_lines=525.
REQ-031 Locked, pixel_in driven as x[2:0] -> rx_pixel matches at rx_x 0..639, rx_y 0..479; rx_valid high 640x480 cycles per frame.
REQ-032 Locked, one line 801 clocks -> locked falls after that line start; err_count 1 (macro defined) or 0 (undefined).
REQ-033 hsync held high 1100 clocks -> SEARCH on hcnt=1023; relock after 3 good frames.
REQ-034 Frame of 524 lines in CHECK -> good count reset; lock needs 2 further good frames.
REQ-035 rst asserted mid-frame while locked -> all outputs 0 immediately; relock on third frame_start after release.

Source files
------------

// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: synchronizes hsync/vsync, measures line and frame
// periods, locks onto the expected timing and emits visible-window pixel
// coordinates.
// Optional feature: define VGA_RX_ERRCNT_EN to build the saturating
// lock-loss counter on err_count; otherwise err_count is tied to zero.
module vga_sync_receiver #(
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_START     = 144,
    parameter int V_START     = 35,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic [2:0] pixel_in,
    output logic [9:0] rx_x,
    output logic [9:0] rx_y,
    output logic       rx_valid,
    output logic [2:0] rx_pixel,
    output logic       frame_start,
    output logic [9:0] line_len,
    output logic [9:0] frame_lines,
    output logic       locked,
    output logic [7:0] err_count
);

    localparam logic [9:0] CNT_MAX = 10'h3FF;
    localparam logic [9:0] H_TOT   = 10'(H_TOTAL);
    localparam logic [9:0] V_TOT   = 10'(V_TOTAL);
    localparam logic [9:0] H_BEG   = 10'(H_START);
    localparam logic [9:0] H_END   = 10'(H_START + H_ACTIVE);
    localparam logic [9:0] V_BEG   = 10'(V_START);
    localparam logic [9:0] V_END   = 10'(V_START + V_ACTIVE);
    localparam logic [7:0] LOCK_N  = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        CHECK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Saturating increment for the 10-bit counters and measurements
    function automatic logic [9:0] sat_inc(input logic [9:0] v);
        return (v == CNT_MAX) ? v : v + 10'd1;
    endfunction

    logic       hs_s1, hs_s2, hs_d;
    logic       vs_s1, vs_s2, vs_d;
    logic [2:0] pixel_p0, pixel_p1;
    logic [9:0] hcnt, vcnt;
    logic       vflag;
    logic       bad;
    state_t     state;
    logic [7:0] good_cnt;

    logic       line_start;
    logic       vs_fall;
    logic       frame_pend;
    logic       fs_now;
    logic [9:0] new_len;
    logic [9:0] new_lines;
    logic       len_bad;
    logic       frame_good;
    logic       watchdog;
    logic       lock_loss;
    logic       in_window;

    // Falling edges are taken between the second sync flop and one more
    // history flop, so the counters see a clean, already-synchronized edge.
    assign line_start = hs_d & ~hs_s2;
    assign vs_fall    = vs_d & ~vs_s2;
    // A vsync fall arriving on the same cycle as the line start is consumed
    // by that line start.
    assign frame_pend = vflag | vs_fall;
    assign fs_now     = line_start & frame_pend;
    assign new_len    = sat_inc(hcnt);
    assign new_lines  = sat_inc(vcnt);
    assign len_bad    = line_start && (new_len != H_TOT);
    // The line ending at the frame boundary belongs to the frame being judged.
    assign frame_good = !bad && !len_bad && (new_lines == V_TOT);
    assign watchdog   = (hcnt == CNT_MAX);
    assign lock_loss  = (state == LOCKED) &&
                        (len_bad || watchdog || (fs_now && new_lines != V_TOT));
    assign in_window  = (hcnt >= H_BEG) && (hcnt < H_END) &&
                        (vcnt >= V_BEG) && (vcnt < V_END);

    // Two-flop sync inputs (idle high) plus edge history; matching pixel delay
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_s1    <= 1'b1;
            hs_s2    <= 1'b1;
            hs_d     <= 1'b1;
            vs_s1    <= 1'b1;
            vs_s2    <= 1'b1;
            vs_d     <= 1'b1;
            pixel_p0 <= 3'd0;
            pixel_p1 <= 3'd0;
        end else begin
            hs_s1    <= hsync_in;
            hs_s2    <= hs_s1;
            hs_d     <= hs_s2;
            vs_s1    <= vsync_in;
            vs_s2    <= vs_s1;
            vs_d     <= vs_s2;
            pixel_p0 <= pixel_in;
            pixel_p1 <= pixel_p0;
        end
    end

    // Horizontal/vertical counters, period measurements and frame boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt        <= 10'd0;
            vcnt        <= 10'd0;
            vflag       <= 1'b0;
            line_len    <= 10'd0;
            frame_lines <= 10'd0;
            frame_start <= 1'b0;
            bad         <= 1'b0;
        end else begin
            frame_start <= fs_now;
            if (line_start) begin
                hcnt     <= 10'd0;
                line_len <= new_len;
                if (frame_pend) begin
                    vcnt        <= 10'd0;
                    frame_lines <= new_lines;
                    vflag       <= 1'b0;
                end else begin
                    vcnt <= sat_inc(vcnt);
                end
            end else begin
                hcnt <= sat_inc(hcnt);
                if (vs_fall) begin
                    vflag <= 1'b1;
                end
            end
            if (fs_now) begin
                bad <= 1'b0;
            end else if (len_bad) begin
                bad <= 1'b1;
            end
        end
    end

    // Lock state machine: SEARCH waits for a frame, CHECK counts good frames
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= SEARCH;
            good_cnt <= 8'd0;
            locked   <= 1'b0;
        end else begin
            case (state)
                SEARCH: begin
                    if (fs_now) begin
                        state    <= CHECK;
                        good_cnt <= 8'd0;
                    end
                end
                CHECK: begin
                    if (watchdog) begin
                        state    <= SEARCH;
                        good_cnt <= 8'd0;
                    end else if (fs_now) begin
                        if (frame_good) begin
                            if (good_cnt + 8'd1 >= LOCK_N) begin
                                state    <= LOCKED;
                                locked   <= 1'b1;
                                good_cnt <= 8'd0;
                            end else begin
                                good_cnt <= good_cnt + 8'd1;
                            end
                        end else begin
                            good_cnt <= 8'd0;
                        end
                    end
                end
                LOCKED: begin
                    if (lock_loss) begin
                        state    <= SEARCH;
                        locked   <= 1'b0;
                        good_cnt <= 8'd0;
                    end
                end
                default: begin
                    state    <= SEARCH;
                    locked   <= 1'b0;
                    good_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Visible-window coordinate and pixel output, zeroed outside the window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_valid <= 1'b0;
            rx_x     <= 10'd0;
            rx_y     <= 10'd0;
            rx_pixel <= 3'd0;
        end else if (locked && in_window) begin
            rx_valid <= 1'b1;
            rx_x     <= hcnt - H_BEG;
            rx_y     <= vcnt - V_BEG;
            rx_pixel <= pixel_p1;
        end else begin
            rx_valid <= 1'b0;
            rx_x     <= 10'd0;
            rx_y     <= 10'd0;
            rx_pixel <= 3'd0;
        end
    end

`ifdef VGA_RX_ERRCNT_EN
    logic [7:0] err_cnt;

    // Lock-loss counter, saturating, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (lock_loss && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_count = err_cnt;
`else
    assign err_count = 8'd0;
`endif

endmodule
